fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, width of all program-counter and address signals.
REQ-002 Parameter INSTR_WIDTH, default 32, width of instruction words.
REQ-003 Parameter DEPTH, default 4, queue entries; power of two, >= 2.
REQ-004 Parameter RESET_PC, default 0, first fetch address after reset; low two bits zero.
REQ-005 Parameter NOP_INSTR, default 32'h00000013, value driven on out_instr when the queue is empty.
REQ-006 clk  input  1  single clock; all state updates on posedge clk.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 imem_addr  output  ADDR_WIDTH  fetch address to instruction memory.
REQ-009 imem_rdata  input  INSTR_WIDTH  instruction at imem_addr, valid in the same cycle (combinational memory).
REQ-010 redirect_valid  input  1  branch/jump taken; discard queued instructions and restart fetch.
REQ-011 redirect_pc  input  ADDR_WIDTH  restart address, sampled when redirect_valid=1.
REQ-012 out_ready  input  1  decode accepts the head entry (deasserted on hazard stall).
REQ-013 out_valid  output  1  head entry holds a valid instruction.
REQ-014 out_instr  output  INSTR_WIDTH  head instruction; NOP_INSTR when out_valid=0.
REQ-015 out_pc  output  ADDR_WIDTH  address of head instruction; 0 when out_valid=0.
REQ-016 occupancy  output  $clog2(DEPTH+1)  number of valid entries, 0..DEPTH.

Function
REQ-017 imem_addr SHALL equal the fetch_pc register combinationally.
REQ-018 pop SHALL occur in a cycle when out_valid=1 and out_ready=1.
REQ-019 push SHALL occur in a cycle when occupancy<DEPTH, or when occupancy==DEPTH and a pop occurs in that cycle; push writes {fetch_pc, imem_rdata} at the tail.
REQ-020 On push, fetch_pc SHALL advance by 4 at the next edge, wrapping modulo 2^ADDR_WIDTH; without push, fetch_pc holds.
REQ-021 occupancy SHALL increment on push-only, decrement on pop-only, hold on push+pop or neither.
REQ-022 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-023 out_valid SHALL equal (occupancy != 0); out_instr/out_pc SHALL be the head entry, registered storage (no combinational path from imem_rdata).
REQ-024 Latency: an instruction pushed at edge N SHALL appear at the head no earlier than the cycle after edge N; empty-queue fetch-to-out_valid latency is exactly 1 cycle.
REQ-025 Steady-state throughput with out_ready=1 SHALL be one instruction per cycle.
REQ-026 redirect_valid=1 SHALL take priority over push and pop: at the next edge occupancy=0, pointers=0, fetch_pc=redirect_pc with bits [1:0] cleared; no entry is written that cycle.
REQ-027 In the cycle after a redirect, out_valid SHALL be 0 and imem_addr SHALL equal the aligned redirect_pc; first redirected instruction is valid one cycle later.
REQ-028 A pop handshake in the same cycle as redirect_valid SHALL still count as consumed by decode; the queue does not re-present that entry.
REQ-029 Back-to-back redirects SHALL each take effect; the last one sampled determines fetch_pc.
REQ-030 out_ready held 0 with queue full SHALL freeze fetch_pc, occupancy and all entries indefinitely.

Reset
REQ-031 reset=1 at a posedge SHALL set fetch_pc=RESET_PC, occupancy=0, head=tail=0; out_valid=0, out_instr=NOP_INSTR, out_pc=0.
REQ-032 reset SHALL take priority over redirect_valid, push and pop, including mid-operation with a full queue.
REQ-033 Entry storage contents need not be cleared; outputs SHALL never expose stale entries while occupancy=0.

Verification (DEPTH=4, RESET_PC=0, memory returns instr = 0x1000_0000 | addr)
REQ-034 Reset released, out_ready=1 -> cycle 1: out_valid=1, out_pc=0, out_instr=0x10000000; then out_pc 4, 8, 12 each cycle, occupancy stays 1.
REQ-035 out_ready=0 for 6 cycles after reset -> occupancy 1,2,3,4,4,4; imem_addr holds 0x10; release -> pops pc 0,4,8,12,16 consecutively with no gap.
REQ-036 Queue holds pc 0..12, redirect_valid=1, redirect_pc=0x102 -> next cycle out_valid=0, occupancy=0, imem_addr=0x100; following cycle out_pc=0x100, out_instr=0x10000100.
REQ-037 Full queue, out_ready=1 and redirect same cycle -> head pc 0 consumed once, never re-presented; next valid out_pc = redirect target.
REQ-038 Full queue plus redirect_valid=1 and reset=1 same edge -> fetch_pc=0, occupancy=0 (reset wins).
REQ-039 RESET_PC=0xFFFFFFF8, out_ready=1 -> out_pc sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch queue sitting between a combinational
// instruction memory and decode. Fetches sequentially from fetch_pc, buffers
// up to DEPTH {pc, instr} entries, and restarts on a taken branch/jump.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   imem_addr         fetch address (the fetch_pc register)
//   imem_rdata        instruction at imem_addr, same cycle
//   redirect_valid/pc flush queue and restart fetch at the aligned pc
//   out_ready         decode accepts the head entry
//   out_valid/instr/pc head entry (NOP_INSTR / 0 when empty)
//   occupancy         number of valid entries, 0..DEPTH
module fetch_queue #(
  parameter int                     ADDR_WIDTH  = 32,
  parameter int                     INSTR_WIDTH = 32,
  parameter int                     DEPTH       = 4,
  parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = '0,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 'h13
) (
  input  logic                         clk,
  input  logic                         reset,
  output logic [ADDR_WIDTH-1:0]        imem_addr,
  input  logic [INSTR_WIDTH-1:0]       imem_rdata,
  input  logic                         redirect_valid,
  input  logic [ADDR_WIDTH-1:0]        redirect_pc,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [INSTR_WIDTH-1:0]       out_instr,
  output logic [ADDR_WIDTH-1:0]        out_pc,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy
);
  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  entry_t                mem [DEPTH];
  logic [PW-1:0]         head, tail;
  logic [OW-1:0]         occ;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  full, pop, push, wr_en;

  assign full  = (occ == OW'(DEPTH));
  assign pop   = (occ != '0) && out_ready;
  // A full queue can still accept the fetched word when the head leaves.
  assign push  = !full || pop;
  // Reset and redirect both suppress the write.
  assign wr_en = push && !redirect_valid && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
    end else if (redirect_valid) begin
      // Any pop this cycle is simply dropped with the rest of the queue,
      // so the consumed head is never re-presented.
      fetch_pc <= {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      head     <= '0;
      tail     <= '0;
      occ      <= '0;
    end else begin
      if (push) begin
        tail     <= tail + PW'(1);
        fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
      end
      if (pop) head <= head + PW'(1);
      if (push && !pop)      occ <= occ + OW'(1);
      else if (pop && !push) occ <= occ - OW'(1);
    end
  end

  // Storage is never cleared; outputs are masked while empty instead.
  always_ff @(posedge clk) begin
    if (wr_en) mem[tail] <= '{pc: fetch_pc, instr: imem_rdata};
  end

  assign imem_addr = fetch_pc;
  assign occupancy = occ;
  assign out_valid = (occ != '0);
  assign out_instr = out_valid ? mem[head].instr : NOP_INSTR;
  assign out_pc    = out_valid ? mem[head].pc    : '0;

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, out_instr, out_pc;
  logic        out_valid;
  logic [2:0]  occupancy;

  logic        reset2, out_valid2;
  logic [31:0] imem_addr2, imem_rdata2, out_instr2, out_pc2;
  logic [2:0]  occupancy2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_rdata  = 32'h1000_0000 | imem_addr;
  assign imem_rdata2 = 32'h1000_0000 | imem_addr2;

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_ready(out_ready), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .occupancy(occupancy));

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .reset(reset2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_ready(1'b1), .out_valid(out_valid2), .out_instr(out_instr2),
    .out_pc(out_pc2), .occupancy(occupancy2));

  // Reference model: a plain queue of fetched (pc, instr) pairs.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int  sz;
    bit  pop;
    if (reset) begin
      m_pc = 32'h0;
      mq.delete();
    end else if (redirect_valid) begin
      m_pc = redirect_pc & ~32'h3;
      mq.delete();
    end else begin
      sz  = mq.size();
      pop = (sz > 0) && out_ready;
      if (pop) void'(mq.pop_front());
      if (sz < DEPTH || pop) begin
        mq.push_back('{pc: m_pc, instr: 32'h1000_0000 | m_pc});
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_model();
    bit v;
    v = mq.size() > 0;
    chk("out_valid", {31'b0, out_valid}, {31'b0, v});
    chk("out_instr", out_instr, v ? mq[0].instr : NOP);
    chk("out_pc", out_pc, v ? mq[0].pc : 32'h0);
    chk("occupancy", {29'b0, occupancy}, mq.size());
    chk("imem_addr", imem_addr, m_pc);
  endtask

  // Model the edge with the inputs currently driven, advance, then compare.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic fill_after_reset();
    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0;
    tick();
    reset = 1'b0;
    repeat (DEPTH) tick();
  endtask

  initial begin
    reset = 1'b1; reset2 = 1'b1; redirect_valid = 1'b0;
    redirect_pc = 32'h0; out_ready = 1'b1;
    #1;
    tick(); tick();
    chk("rst_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_instr", out_instr, NOP);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);

    // Streaming: one instruction per cycle, occupancy stays 1.
    reset = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stream_pc", out_pc, 32'(4 * i));
      chk("stream_occ", {29'b0, occupancy}, 32'd1);
    end
    chk("stream_instr", out_instr, 32'h1000_000C);

    // Stall fills the queue then freezes; release drains with no gap.
    reset = 1'b1; tick(); reset = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("stall_occ", {29'b0, occupancy}, (i < 4) ? 32'(i + 1) : 32'd4);
    end
    chk("stall_addr", imem_addr, 32'h10);
    chk("stall_head", out_pc, 32'h0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("drain_pc", out_pc, 32'(4 * i));
    end

    // Redirect with a full, stalled queue.
    fill_after_reset();
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    chk("redir_valid", {31'b0, out_valid}, 32'h0);
    chk("redir_occ", {29'b0, occupancy}, 32'h0);
    chk("redir_addr", imem_addr, 32'h100);
    tick();
    chk("redir_pc", out_pc, 32'h100);
    chk("redir_instr", out_instr, 32'h1000_0100);

    // Pop and redirect in the same cycle: head is not re-presented.
    fill_after_reset();
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    chk("popredir_valid", {31'b0, out_valid}, 32'h0);
    tick();
    chk("popredir_pc", out_pc, 32'h200);

    // Back-to-back redirects: last one wins.
    redirect_valid = 1'b1; redirect_pc = 32'h300; tick();
    redirect_pc = 32'h407; tick();
    redirect_valid = 1'b0;
    chk("b2b_addr", imem_addr, 32'h404);

    // Reset beats redirect on a full queue.
    fill_after_reset();
    reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h500;
    tick();
    chk("rstwin_addr", imem_addr, 32'h0);
    chk("rstwin_occ", {29'b0, occupancy}, 32'h0);
    reset = 1'b0; redirect_valid = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      out_ready      = ($urandom_range(3) != 0);
      redirect_valid = ($urandom_range(15) == 0);
      redirect_pc    = $urandom;
      reset          = ($urandom_range(63) == 0);
      tick();
    end
    reset = 1'b0; redirect_valid = 1'b0;

    // Fetch pc wraps across the top of the address space.
    reset2 = 1'b0;
    tick();
    chk("wrap_pc0", out_pc2, 32'hFFFF_FFF8);
    tick();
    chk("wrap_pc1", out_pc2, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc2", out_pc2, 32'h0000_0000);
    chk("wrap_instr", out_instr2, 32'h1000_0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
